// File: rtl/fg_pkg.sv
// Shared types and defaults for the function-generator parameter controller.
// Holds the FSM encoding, step table and tuning-word constants.
package fg_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, LOAD = 2'd2} fgState_t;

    localparam int FREQ_W = 20;
    localparam int TW_W   = 32;
    localparam int PROD_W = 52;

    localparam logic [FREQ_W-1:0] FREQ_MIN_D = 20'd1;
    localparam logic [FREQ_W-1:0] FREQ_MAX_D = 20'd1_000_000;
    localparam logic [FREQ_W-1:0] FREQ_RST_D = 20'd1000;
    localparam logic [TW_W-1:0]   TW_MULT_D  = 32'd87961;
    localparam int                TW_SHIFT_D = 10;

    localparam logic [2:0] STEP_LAST = 3'd5;

    function automatic logic [FREQ_W-1:0] stepHz(input logic [2:0] idx);
        case (idx)
            3'd0:    stepHz = 20'd1;
            3'd1:    stepHz = 20'd10;
            3'd2:    stepHz = 20'd100;
            3'd3:    stepHz = 20'd1000;
            3'd4:    stepHz = 20'd10000;
            3'd5:    stepHz = 20'd100000;
            default: stepHz = 20'd1;
        endcase
    endfunction
endpackage

// File: rtl/fg_param_ctrl_if.sv
// Button pulses in, frequency/waveform/tuning-word state out.
interface fg_param_ctrl_if;
    import fg_pkg::*;

    logic              iBtnWave;
    logic              iBtnStep;
    logic              iBtnUp;
    logic              iBtnDown;
    logic [1:0]        oWaveSel;
    logic [2:0]        oStepSel;
    logic [FREQ_W-1:0] oFreqHz;
    logic [TW_W-1:0]   oTuneWord;
    logic              oUpdate;
    logic              oBusy;

    modport master (output iBtnWave, iBtnStep, iBtnUp, iBtnDown,
                    input  oWaveSel, oStepSel, oFreqHz, oTuneWord, oUpdate, oBusy);
    modport slave  (input  iBtnWave, iBtnStep, iBtnUp, iBtnDown,
                    output oWaveSel, oStepSel, oFreqHz, oTuneWord, oUpdate, oBusy);
endinterface

// File: rtl/fg_seq_mult.sv
// Sequential shift-add multiplier, one bit of 'a' per cycle.
// Comes out of reset already running on the reset operands.
module fg_seq_mult
    import fg_pkg::*;
#(
    parameter int             A_W   = FREQ_W,
    parameter int             B_W   = TW_W,
    parameter int             P_W   = PROD_W,
    parameter logic [A_W-1:0] A_RST = '0,
    parameter logic [B_W-1:0] B_RST = '0
) (
    input  logic           Fg_CLK,
    input  logic           Ext_RESETn,
    input  logic           start,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic           done,
    output logic [P_W-1:0] product
);
    localparam int             CNT_W = $clog2(A_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(A_W - 1);

    logic [A_W-1:0]   aSh;
    logic [P_W-1:0]   bSh;
    logic [P_W-1:0]   acc;
    logic [CNT_W-1:0] cnt;
    logic             run;

    always_ff @(posedge Fg_CLK or negedge Ext_RESETn) begin
        if (!Ext_RESETn) begin
            aSh <= A_RST;
            bSh <= {{(P_W-B_W){1'b0}}, B_RST};
            acc <= '0;
            cnt <= '0;
            run <= 1'b1;
        end else if (start) begin
            aSh <= a;
            bSh <= {{(P_W-B_W){1'b0}}, b};
            acc <= '0;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            acc <= acc + (aSh[0] ? bSh : '0);
            aSh <= aSh >> 1;
            bSh <= bSh << 1;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) run <= 1'b0;
        end
    end

    // done marks the cycle whose edge adds the final partial product
    assign done    = run && (cnt == LAST);
    assign product = acc;
endmodule

// File: rtl/fg_param_ctrl.sv
// Front-panel parameter controller: buttons adjust waveform, step and
// frequency; each frequency change recomputes the DDS tuning word.
module fg_param_ctrl
    import fg_pkg::*;
#(
    parameter logic [FREQ_W-1:0] FREQ_MIN = FREQ_MIN_D,
    parameter logic [FREQ_W-1:0] FREQ_MAX = FREQ_MAX_D,
    parameter logic [FREQ_W-1:0] FREQ_RST = FREQ_RST_D,
    parameter logic [TW_W-1:0]   TW_MULT  = TW_MULT_D,
    parameter int                TW_SHIFT = TW_SHIFT_D
) (
    input  logic            Fg_CLK,
    input  logic            Ext_RESETn,
    fg_param_ctrl_if.slave  bus
);
    fgState_t          state, stateNxt;
    logic [1:0]        waveSel;
    logic [2:0]        stepSel;
    logic [FREQ_W-1:0] freqHz, freqNxt, stepVal;
    logic [TW_W-1:0]   tuneWord;
    logic              update, busy;
    logic              doWave, doStep, doUp, doDown, calcReq;
    logic              multStart, multDone, loadTw;
    logic [FREQ_W:0]   sumUp, floorDn;
    logic [PROD_W-1:0] product;

    // Button priority and saturating frequency arithmetic
    always_comb begin
        doWave  = (state == IDLE) & bus.iBtnWave;
        doStep  = (state == IDLE) & ~bus.iBtnWave & bus.iBtnStep;
        doUp    = (state == IDLE) & ~bus.iBtnWave & ~bus.iBtnStep & bus.iBtnUp;
        doDown  = (state == IDLE) & ~bus.iBtnWave & ~bus.iBtnStep & ~bus.iBtnUp & bus.iBtnDown;
        calcReq = doUp | doDown;
        stepVal = stepHz(stepSel);
        sumUp   = {1'b0, freqHz} + {1'b0, stepVal};
        floorDn = {1'b0, stepVal} + {1'b0, FREQ_MIN};
        freqNxt = freqHz;
        if (doUp)
            freqNxt = (sumUp > {1'b0, FREQ_MAX}) ? FREQ_MAX : sumUp[FREQ_W-1:0];
        else if (doDown)
            freqNxt = ({1'b0, freqHz} < floorDn) ? FREQ_MIN : freqHz - stepVal;
    end

    always_ff @(posedge Fg_CLK or negedge Ext_RESETn) begin
        if (!Ext_RESETn) state <= CALC;
        else             state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE:    if (calcReq)  stateNxt = CALC;
            CALC:    if (multDone) stateNxt = LOAD;
            LOAD:    stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    always_comb begin
        multStart = (state == IDLE) & calcReq;
        loadTw    = (state == LOAD);
    end

    // Multiplier latches the new frequency at start, so freqHz is free to hold
    fg_seq_mult #(
        .A_W(FREQ_W), .B_W(TW_W), .P_W(PROD_W),
        .A_RST(FREQ_RST), .B_RST(TW_MULT)
    ) uMult (
        .Fg_CLK    (Fg_CLK),
        .Ext_RESETn(Ext_RESETn),
        .start     (multStart),
        .a         (freqNxt),
        .b         (TW_MULT),
        .done      (multDone),
        .product   (product)
    );

    always_ff @(posedge Fg_CLK or negedge Ext_RESETn) begin
        if (!Ext_RESETn) begin
            waveSel  <= '0;
            stepSel  <= '0;
            freqHz   <= FREQ_RST;
            tuneWord <= '0;
            update   <= 1'b0;
            busy     <= 1'b1;
        end else begin
            update <= loadTw;
            if (loadTw)  tuneWord <= TW_W'(product >> TW_SHIFT);
            if (doWave)  waveSel  <= waveSel + 1'b1;
            if (doStep)  stepSel  <= (stepSel == STEP_LAST) ? 3'd0 : stepSel + 1'b1;
            if (calcReq) freqHz   <= freqNxt;
            // busy covers the strobe cycle itself, then drops
            if (multStart)   busy <= 1'b1;
            else if (update) busy <= 1'b0;
        end
    end

    assign bus.oWaveSel  = waveSel;
    assign bus.oStepSel  = stepSel;
    assign bus.oFreqHz   = freqHz;
    assign bus.oTuneWord = tuneWord;
    assign bus.oUpdate   = update;
    assign bus.oBusy     = busy;
endmodule

// File: doc/fg_param_ctrl.md
FG_PARAM_CTRL -- requirements
Module: fg_param_ctrl

Interface
REQ-001 Parameter FREQ_MIN, default 20'd1, lowest selectable output frequency in Hz.
REQ-002 Parameter FREQ_MAX, default 20'd1_000_000, highest selectable output frequency in Hz.
REQ-003 Parameter FREQ_RST, default 20'd1000, frequency loaded at reset in Hz.
REQ-004 Parameter TW_MULT, default 32'd87961, tuning-word multiplier: 2^42 / Fclk for 50 MHz.
REQ-005 Parameter TW_SHIFT, default 10, right shift applied to the product.
REQ-006 Fg_CLK  input  1  system clock; all logic SHALL be on its rising edge.
REQ-007 Ext_RESETn  input  1  reset: asynchronous, active-low.
REQ-008 iBtnWave  input  1  debounced one-cycle pulse: next waveform.
REQ-009 iBtnStep  input  1  debounced one-cycle pulse: next step size.
REQ-010 iBtnUp  input  1  debounced one-cycle pulse: frequency up by one step.
REQ-011 iBtnDown  input  1  debounced one-cycle pulse: frequency down by one step.
REQ-012 oWaveSel  output  2  waveform: 0 sine, 1 square, 2 triangle, 3 sawtooth.
REQ-013 oStepSel  output  3  step index 0..5: 1, 10, 100, 1k, 10k, 100k Hz.
REQ-014 oFreqHz  output  20  current frequency in Hz.
REQ-015 oTuneWord  output  32  DDS phase increment for the phase accumulator.
REQ-016 oUpdate  output  1  one-cycle strobe: oTuneWord has just changed.
REQ-017 oBusy  output  1  high while a tuning-word calculation is in progress.

Function
REQ-018 FSM states SHALL be IDLE, CALC and LOAD; button pulses SHALL be accepted only in IDLE.
REQ-019 Pulses arriving in CALC or LOAD SHALL be discarded with no side effect.
REQ-020 Simultaneous pulses: only the highest-priority pulse SHALL act, in the order Wave > Step > Up > Down.
REQ-021 iBtnWave SHALL increment oWaveSel at the next edge, wrapping 3->0, with no calculation started and oBusy staying low.
REQ-022 iBtnStep SHALL increment oStepSel at the next edge, wrapping 5->0, with no calculation started.
REQ-023 iBtnUp: oFreqHz <= min(oFreqHz + step, FREQ_MAX), using a 21-bit intermediate with no overflow.
REQ-024 iBtnDown: oFreqHz <= max(oFreqHz - step, FREQ_MIN), with the comparison done before subtraction and no underflow.
REQ-025 An Up or Down pulse SHALL start a calculation even when saturation leaves oFreqHz unchanged.
REQ-026 Starting a calculation SHALL set state CALC, oBusy=1, bit counter=0.
REQ-027 The product SHALL be formed as oFreqHz x TW_MULT by sequential shift-add, one multiplier bit per cycle, into a 52-bit accumulator.
REQ-028 CALC SHALL last exactly 20 cycles and then go to LOAD.
REQ-029 LOAD SHALL register oTuneWord = accumulator[TW_SHIFT+31:TW_SHIFT], assert oUpdate for one cycle, and return to IDLE.
REQ-030 Latency: oUpdate SHALL be high exactly 22 cycles after the cycle in which the accepted pulse was high.
REQ-031 oBusy SHALL be high from the cycle after acceptance through the oUpdate cycle inclusive.
REQ-032 oFreqHz SHALL hold steady during CALC/LOAD; the multiplier SHALL use a latched copy.

Reset
REQ-033 On reset assertion, state SHALL be CALC with bit counter=0.
REQ-034 Reset values SHALL be oWaveSel=0, oStepSel=0, oFreqHz=FREQ_RST, oTuneWord=0, oUpdate=0, oBusy=1.
REQ-035 After release, the first oUpdate SHALL occur 21 cycles after release, with oTuneWord equal to the value for FREQ_RST (1000 Hz -> 32'd85899).
REQ-036 Reset asserted mid-CALC SHALL abort the calculation immediately, with no oUpdate produced.

Structure
REQ-037 The state encoding, step table (1..100000), FREQ_MIN/MAX/RST, TW_MULT and TW_SHIFT defaults SHALL live in shared package fg_pkg.
REQ-038 The shift-add multiplier SHALL be one sub-module, fg_seq_mult (start/done handshake, 20x32 -> 52).

Verification
REQ-039 Release reset, no stimulus -> oUpdate pulse 21 cycles later, oTuneWord=85899, oFreqHz=1000, oBusy falls after that pulse.
REQ-040 Pulse iBtnWave 5 times, spaced 2400 cycles -> oWaveSel sequence 1,2,3,0,1; oBusy stays 0.
REQ-041 Pulse iBtnStep 3 times, then iBtnUp -> oStepSel=3, oFreqHz=2000, oUpdate at +22 cycles, oTuneWord=171798.
REQ-042 With oStepSel=5 and oFreqHz=950000, pulse Up -> oFreqHz=1000000. Then set oStepSel=0 and oFreqHz=1, pulse Down -> oFreqHz stays 1 and oUpdate still fires.
REQ-043 iBtnUp and iBtnWave in the same cycle -> only oWaveSel increments; a second iBtnUp during CALC is discarded and oFreqHz is unchanged.
REQ-044 Assert Ext_RESETn low 10 cycles into CALC -> all outputs return to reset values at once, with no oUpdate before the post-release sequence.
